// File: rtl/sig_mag_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sig_mag_pkg
// Brief    : Shared states, sizing helpers for the sign/magnitude packer.
// Revision : 1.0
// ============================================================================
package sig_mag_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DRAIN   = 2'd2
   } state_t;

   function automatic int samples_per_word(input int word_w);
      return word_w / 2;
   endfunction

   // Width of a counter holding 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sig_mag_word_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sig_mag_word_fifo
// Brief    : First-word-fall-through word FIFO; a push on full succeeds when
//            a pop happens in the same cycle.
// Revision : 1.0
// ============================================================================
module sig_mag_word_fifo
   import sig_mag_pkg::*;
#(
   parameter int WORD_W     = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                                clk,
   input  logic                                resetn,
   input  logic                                push,
   input  logic [WORD_W-1:0]                   push_data,
   input  logic                                pop,
   output logic [WORD_W-1:0]                   pop_data,
   output logic                                full,
   output logic                                empty,
   output logic [level_width(FIFO_DEPTH)-1:0]  level
);

   localparam int c_PTR_W = $clog2(FIFO_DEPTH);
   localparam int c_LVL_W = level_width(FIFO_DEPTH);

   logic [WORD_W-1:0]  r_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_LVL_W-1:0] r_level;
   logic               w_pop_ok;
   logic               w_push_ok;

   assign full      = (r_level == c_LVL_W'(FIFO_DEPTH));
   assign empty     = (r_level == '0);
   assign w_pop_ok  = pop & ~empty;
   assign w_push_ok = push & (~full | w_pop_ok);
   assign level     = r_level;
   // Head is masked while empty so stale storage never shows on the port.
   assign pop_data  = empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_level <= r_level + c_LVL_W'(1);
            2'b01:   r_level <= r_level - c_LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/sig_mag_packer.sv
`default_nettype none
// ============================================================================
// Module   : sig_mag_packer
// Brief    : Packs {sig,mag} samples into words for a fixed-length capture
//            window and streams them out through a word FIFO.
// Revision : 1.0
// ============================================================================
module sig_mag_packer
   import sig_mag_pkg::*;
#(
   parameter int WORD_W     = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int LEN_W      = 16
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          in_valid,
   input  logic                          sig,
   input  logic                          mag,
   input  logic                          start,
   input  logic [LEN_W-1:0]              length,
   output logic [WORD_W-1:0]             out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          busy,
   output logic                          done,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int c_SAMPLES_PER_WORD = samples_per_word(WORD_W);
   localparam int c_SCNT_W           = cnt_width(c_SAMPLES_PER_WORD);
   localparam int c_LVL_W            = level_width(FIFO_DEPTH);
   localparam logic [c_SCNT_W-1:0] c_LAST_SAMPLE = c_SCNT_W'(c_SAMPLES_PER_WORD - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [LEN_W-1:0]    r_len;
   logic [LEN_W-1:0]    r_word_cnt;
   logic [c_SCNT_W-1:0] r_samp_cnt;
   logic [WORD_W-1:0]   r_shift;
   logic                r_overflow;
   logic                r_done;

   logic                w_start_idle;
   logic                w_take;
   logic                w_word_done;
   logic                w_last_word;
   logic                w_pop;
   logic                w_full;
   logic                w_empty;
   logic                w_drain_done;
   logic [WORD_W-1:0]   w_word;
   logic [c_LVL_W-1:0]  w_level;

   // New samples enter at the top and shift down, so sample 0 ends in the LSBs.
   assign w_word       = {sig, mag, r_shift[WORD_W-1:2]};
   assign w_start_idle = (r_state == IDLE) & start;
   assign w_take       = (r_state == CAPTURE) & in_valid;
   assign w_word_done  = w_take & (r_samp_cnt == c_LAST_SAMPLE);
   assign w_last_word  = w_word_done & ((r_word_cnt + LEN_W'(1)) == r_len);
   assign w_pop        = out_valid & out_ready;
   // Look ahead one pop so done lands in the cycle right after the last pop.
   assign w_drain_done = w_empty | ((w_level == c_LVL_W'(1)) & w_pop);

   assign out_valid  = ~w_empty;
   assign busy       = (r_state != IDLE);
   assign done       = r_done;
   assign overflow   = r_overflow;
   assign fifo_level = w_level;

   sig_mag_word_fifo #(
      .WORD_W     (WORD_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (w_word_done),
      .push_data (w_word),
      .pop       (w_pop),
      .pop_data  (out_data),
      .full      (w_full),
      .empty     (w_empty),
      .level     (w_level)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (start && (length != '0)) begin
               w_state_nxt = CAPTURE;
            end
         end
         CAPTURE: begin
            if (w_last_word) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (w_drain_done) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_len      <= '0;
         r_word_cnt <= '0;
         r_samp_cnt <= '0;
         r_shift    <= '0;
         r_overflow <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_start_idle) begin
            r_len      <= length;
            r_word_cnt <= '0;
            r_samp_cnt <= '0;
            r_shift    <= '0;
            r_overflow <= 1'b0;
            r_done     <= (length == '0);
         end else begin
            if (w_take) begin
               r_shift    <= w_word;
               r_samp_cnt <= w_word_done ? '0 : r_samp_cnt + c_SCNT_W'(1);
            end
            // Dropped words still advance the counter: the window is sample-timed.
            if (w_word_done) begin
               r_word_cnt <= r_word_cnt + LEN_W'(1);
            end
            if (w_word_done && w_full && !w_pop) begin
               r_overflow <= 1'b1;
            end
            if ((r_state == DRAIN) && w_drain_done) begin
               r_done <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sig_mag_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sig_mag_packer
// Brief    : Directed self-checking bench for sig_mag_packer.
// Revision : 1.0
// ============================================================================
module tb_sig_mag_packer;
   import sig_mag_pkg::*;

   localparam int WORD_W     = 32;
   localparam int FIFO_DEPTH = 8;
   localparam int LEN_W      = 16;
   // Alternating {1,0},{0,1} samples give nibble 4'b0110 in every position.
   localparam logic [31:0] c_PATTERN_WORD = 32'h6666_6666;

   logic              clk = 1'b0;
   logic              resetn;
   logic              in_valid;
   logic              sig;
   logic              mag;
   logic              start;
   logic [LEN_W-1:0]  length;
   logic [WORD_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              busy;
   logic              done;
   logic              overflow;
   logic [3:0]        fifo_level;

   int n_checks = 0;
   int n_errors = 0;
   int lat;

   always #5 clk = ~clk;

   sig_mag_packer #(
      .WORD_W     (WORD_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .LEN_W      (LEN_W)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .in_valid   (in_valid),
      .sig        (sig),
      .mag        (mag),
      .start      (start),
      .length     (length),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow),
      .fifo_level (fifo_level)
   );

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic issue_start(input logic [LEN_W-1:0] len);
      start  = 1'b1;
      length = len;
      tick();
      start  = 1'b0;
   endtask

   // Streams n pattern samples (pattern index starts at first); gapped inserts
   // an idle cycle after each sample. Reports the cycle out_valid first rose.
   task automatic run_stream(input int gapped, input int first, input int n, output int first_valid_cyc);
      int cyc = 0;
      int k   = 0;
      int idx;
      first_valid_cyc = -1;
      while (k < n) begin
         if (gapped == 0 || (cyc % 2) == 0) begin
            idx      = first + k;
            in_valid = 1'b1;
            sig      = ((idx % 2) == 0);
            mag      = ((idx % 2) == 1);
            k++;
         end else begin
            in_valid = 1'b0;
         end
         tick();
         cyc++;
         if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      in_valid = 1'b0;
      sig      = 1'b0;
      mag      = 1'b0;
   endtask

   task automatic drain(input int exp_words, input string tag);
      int cnt  = 0;
      bit seen = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 200 && !seen; i++) begin
         if (out_valid) begin
            check_value({tag, "_data"}, out_data, c_PATTERN_WORD);
            cnt++;
         end
         tick();
         if (done) seen = 1'b1;
      end
      out_ready = 1'b0;
      check_value({tag, "_count"}, 32'(cnt), 32'(exp_words));
      check_value({tag, "_done"}, 32'(seen), 32'd1);
      check_value({tag, "_busy_idle"}, 32'(busy), 32'd0);
      tick();
      check_value({tag, "_done_once"}, 32'(done), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      resetn    = 1'b0;
      in_valid  = 1'b0;
      sig       = 1'b0;
      mag       = 1'b0;
      start     = 1'b0;
      length    = '0;
      out_ready = 1'b0;
      tick();
      tick();
      check_value("rst_out_data",  out_data,          32'd0);
      check_value("rst_out_valid", 32'(out_valid),    32'd0);
      check_value("rst_busy",      32'(busy),         32'd0);
      check_value("rst_done",      32'(done),         32'd0);
      check_value("rst_overflow",  32'(overflow),     32'd0);
      check_value("rst_level",     32'(fifo_level),   32'd0);
      resetn = 1'b1;
      tick();

      // Basic capture, two words, ready held low until both are stored.
      issue_start(16'd2);
      check_value("basic_busy", 32'(busy), 32'd1);
      run_stream(0, 0, 32, lat);
      check_value("basic_latency", 32'(lat), 32'd16);
      check_value("basic_state",   32'(dut.r_state), 32'(DRAIN));
      check_value("basic_level",   32'(fifo_level), 32'd2);
      check_value("basic_word",    out_data, c_PATTERN_WORD);
      check_value("basic_ovf",     32'(overflow), 32'd0);
      out_ready = 1'b1;
      tick();
      check_value("basic_level_pop1", 32'(fifo_level), 32'd1);
      check_value("basic_word2",      out_data, c_PATTERN_WORD);
      check_value("basic_no_done",    32'(done), 32'd0);
      tick();
      check_value("basic_done",       32'(done), 32'd1);
      check_value("basic_idle",       32'(busy), 32'd0);
      check_value("basic_empty",      32'(out_valid), 32'd0);
      out_ready = 1'b0;
      tick();
      check_value("basic_done_once",  32'(done), 32'd0);

      // Gapped valid: sample 15 lands 30 cycles after sample 0.
      issue_start(16'd1);
      run_stream(1, 0, 16, lat);
      check_value("gap_latency", 32'(lat), 32'd31);
      check_value("gap_word",    out_data, c_PATTERN_WORD);
      drain(1, "gap");

      // Backpressure overflow: 10 words into an 8-deep FIFO.
      issue_start(16'd10);
      run_stream(0, 0, 128, lat);
      check_value("bp_level8",     32'(fifo_level), 32'd8);
      check_value("bp_ovf_before", 32'(overflow),   32'd0);
      run_stream(0, 0, 16, lat);
      check_value("bp_level_sat",  32'(fifo_level), 32'd8);
      check_value("bp_ovf_after9", 32'(overflow),   32'd1);
      check_value("bp_state_cap",  32'(dut.r_state), 32'(CAPTURE));
      run_stream(0, 0, 16, lat);
      check_value("bp_state_drain", 32'(dut.r_state), 32'(DRAIN));
      drain(8, "bp");
      check_value("bp_ovf_sticky", 32'(overflow), 32'd1);

      // Full FIFO with a pop in the completing cycle: push must be accepted.
      issue_start(16'd9);
      check_value("fp_ovf_cleared", 32'(overflow), 32'd0);
      run_stream(0, 0, 128, lat);
      run_stream(0, 0, 15, lat);
      check_value("fp_level_full", 32'(fifo_level), 32'd8);
      out_ready = 1'b1;
      run_stream(0, 15, 1, lat);
      check_value("fp_level_kept", 32'(fifo_level), 32'd8);
      check_value("fp_no_ovf",     32'(overflow),   32'd0);
      check_value("fp_state",      32'(dut.r_state), 32'(DRAIN));
      drain(8, "fp");

      // length=0: done once, never busy.
      issue_start(16'd0);
      check_value("len0_done", 32'(done), 32'd1);
      check_value("len0_busy", 32'(busy), 32'd0);
      tick();
      check_value("len0_done_once", 32'(done), 32'd0);
      check_value("len0_busy2",     32'(busy), 32'd0);

      // start during CAPTURE is ignored; original length of 1 word stands.
      issue_start(16'd1);
      run_stream(0, 0, 8, lat);
      start  = 1'b1;
      length = 16'd5;
      tick();
      start  = 1'b0;
      run_stream(0, 8, 8, lat);
      check_value("rs_state", 32'(dut.r_state), 32'(DRAIN));
      check_value("rs_level", 32'(fifo_level),  32'd1);
      drain(1, "rs");

      // Reset mid-capture with one word already buffered.
      issue_start(16'd2);
      run_stream(0, 0, 21, lat);
      check_value("mr_level_pre", 32'(fifo_level), 32'd1);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      check_value("mr_out_data",  out_data,        32'd0);
      check_value("mr_out_valid", 32'(out_valid),  32'd0);
      check_value("mr_busy",      32'(busy),       32'd0);
      check_value("mr_done",      32'(done),       32'd0);
      check_value("mr_overflow",  32'(overflow),   32'd0);
      check_value("mr_level",     32'(fifo_level), 32'd0);
      tick();
      check_value("mr_no_done",   32'(done),       32'd0);
      issue_start(16'd1);
      run_stream(0, 0, 16, lat);
      check_value("mr_new_level", 32'(fifo_level), 32'd1);
      drain(1, "mr");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
